// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatch scheduler and the decoder.
// Holds the reservation-station encoding, credit sizing, the FSM state
// type and a one-hot helper used to build write strobes.
package dispatch_pkg;

    localparam int RS_DEPTH = 8;
    localparam int CNT_W    = $clog2(RS_DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RS_DEPTH);

    // Station encoding shared with the decoder's rs_num field
    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_SFU = 2'b01;
    localparam logic [1:0] RS_BRU = 2'b10;
    localparam logic [1:0] RS_AGU = 2'b11;

    typedef enum logic {
        SLOT1_PENDING = 1'b0,
        SLOT2_PENDING = 1'b1
    } sched_state_t;

    function automatic logic [3:0] onehot(input logic [1:0] num);
        return 4'b0001 << num;
    endfunction

endpackage

// File: rtl/dispatch_scheduler_if.sv
// Decode <-> dispatch scheduler bus.
// master: decode side (drives instruction slots, releases, flush)
// slave : scheduler side (drives write strobes, dispatch/advance, credits)
//   flush, de_valid_1/2, rs_write_de_1/2, rs_num_de_1/2, rs_release
//   rs_we_1/2, dispatch_1/2, de_advance, rs_free_cnt, credit_err
interface dispatch_scheduler_if;
    import dispatch_pkg::*;

    logic                       flush;
    logic                       de_valid_1;
    logic                       de_valid_2;
    logic                       rs_write_de_1;
    logic                       rs_write_de_2;
    logic [1:0]                 rs_num_de_1;
    logic [1:0]                 rs_num_de_2;
    logic [3:0]                 rs_release;
    logic [3:0]                 rs_we_1;
    logic [3:0]                 rs_we_2;
    logic                       dispatch_1;
    logic                       dispatch_2;
    logic                       de_advance;
    logic [3:0][CNT_W-1:0]      rs_free_cnt;
    logic                       credit_err;

    modport master (
        output flush, de_valid_1, de_valid_2, rs_write_de_1, rs_write_de_2,
               rs_num_de_1, rs_num_de_2, rs_release,
        input  rs_we_1, rs_we_2, dispatch_1, dispatch_2, de_advance,
               rs_free_cnt, credit_err
    );

    modport slave (
        input  flush, de_valid_1, de_valid_2, rs_write_de_1, rs_write_de_2,
               rs_num_de_1, rs_num_de_2, rs_release,
        output rs_we_1, rs_we_2, dispatch_1, dispatch_2, de_advance,
               rs_free_cnt, credit_err
    );

endinterface

// File: rtl/rs_credit_counter.sv
// Free-entry counter for one reservation station.
// Ports: clk, reset (sync, active-low), flush, alloc (0..2 entries taken),
//        release_en (one entry freed), count (registered free entries),
//        overflow (pulse: release seen while already full and nothing taken).
module rs_credit_counter
    import dispatch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       alloc,
    input  logic             release_en,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [CNT_W:0] next_count;

    // Extra MSB keeps the intermediate sum from wrapping before saturation
    always_comb begin
        next_count = {1'b0, count} + (CNT_W+1)'(release_en) - (CNT_W+1)'(alloc);
        overflow   = 1'b0;
        if (!flush && release_en && alloc == 2'd0 && count == DEPTH_CNT) begin
            overflow   = 1'b1;
            next_count = {1'b0, DEPTH_CNT};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            count <= DEPTH_CNT;
        end else begin
            count <= next_count[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// Credit-based dispatch controller between dual-issue decode and the four
// reservation stations. Grants are combinational from registered credits.
// Ports: clk, reset (sync, active-low), bus (dispatch_scheduler_if.slave).
module dispatch_scheduler
    import dispatch_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    dispatch_scheduler_if.slave    bus
);

    sched_state_t     state;
    sched_state_t     next_state;
    logic [3:0][1:0]  alloc;
    logic [3:0]       overflow;
    logic [3:0][CNT_W-1:0] free_cnt;

    logic             need_1;
    logic             need_2;
    logic             fit_1;
    logic             fit_2_pair;
    logic             fit_2_single;
    logic [CNT_W-1:0] need_2_cnt;

    assign need_1 = bus.de_valid_1 & bus.rs_write_de_1;
    assign need_2 = bus.de_valid_2 & bus.rs_write_de_2;

    // Slot 2 needs two entries when slot 1 targets the same station in the same cycle
    assign need_2_cnt   = (need_1 && bus.rs_num_de_1 == bus.rs_num_de_2) ? CNT_W'(2) : CNT_W'(1);
    assign fit_1        = !need_1 || (free_cnt[bus.rs_num_de_1] >= CNT_W'(1));
    assign fit_2_pair   = !need_2 || (free_cnt[bus.rs_num_de_2] >= need_2_cnt);
    assign fit_2_single = !need_2 || (free_cnt[bus.rs_num_de_2] >= CNT_W'(1));

    // Grant decision; reset and flush suppress every strobe
    always_comb begin
        bus.dispatch_1 = 1'b0;
        bus.dispatch_2 = 1'b0;
        bus.de_advance = 1'b0;
        next_state     = state;
        if (reset && !bus.flush) begin
            if (state == SLOT1_PENDING) begin
                if (bus.de_valid_1 && fit_1) begin
                    bus.dispatch_1 = 1'b1;
                    if (!bus.de_valid_2) begin
                        bus.de_advance = 1'b1;
                    end else if (fit_2_pair) begin
                        bus.dispatch_2 = 1'b1;
                        bus.de_advance = 1'b1;
                    end else begin
                        next_state = SLOT2_PENDING;
                    end
                end
            end else begin
                if (bus.de_valid_2 && fit_2_single) begin
                    bus.dispatch_2 = 1'b1;
                    bus.de_advance = 1'b1;
                    next_state     = SLOT1_PENDING;
                end
            end
        end
    end

    assign bus.rs_we_1 = (need_1 && bus.dispatch_1) ? onehot(bus.rs_num_de_1) : 4'b0000;
    assign bus.rs_we_2 = (need_2 && bus.dispatch_2) ? onehot(bus.rs_num_de_2) : 4'b0000;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            alloc[r] = {1'b0, bus.rs_we_1[r]} + {1'b0, bus.rs_we_2[r]};
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_credit
            rs_credit_counter u_counter (
                .clk        (clk),
                .reset      (reset),
                .flush      (bus.flush),
                .alloc      (alloc[g]),
                .release_en (bus.rs_release[g]),
                .count      (free_cnt[g]),
                .overflow   (overflow[g])
            );
        end
    endgenerate

    assign bus.rs_free_cnt = free_cnt;

    // A pending slot 2 is dropped by either reset or flush
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= SLOT1_PENDING;
            bus.credit_err <= 1'b0;
        end else begin
            state <= bus.flush ? SLOT1_PENDING : next_state;
            if (|overflow) begin
                bus.credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed self-checking bench for dispatch_scheduler (RS_DEPTH = 8).
module tb_dispatch_scheduler;
    import dispatch_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    dispatch_scheduler_if bus();

    dispatch_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v1, input logic w1, input logic [1:0] n1,
                                 input logic v2, input logic w2, input logic [1:0] n2,
                                 input logic [3:0] rel, input logic fl);
        bus.de_valid_1    = v1;
        bus.rs_write_de_1 = w1;
        bus.rs_num_de_1   = n1;
        bus.de_valid_2    = v2;
        bus.rs_write_de_2 = w2;
        bus.rs_num_de_2   = n2;
        bus.rs_release    = rel;
        bus.flush         = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, RS_ALU, 0, 0, RS_ALU, 4'b0000, 0);
    endtask

    // Grant outputs packed as {dispatch_1, dispatch_2, de_advance, rs_we_1, rs_we_2}
    function automatic logic [31:0] grants();
        return {21'd0, bus.dispatch_1, bus.dispatch_2, bus.de_advance, bus.rs_we_1, bus.rs_we_2};
    endfunction

    function automatic logic [31:0] counts();
        return {16'd0, bus.rs_free_cnt[3], bus.rs_free_cnt[2], bus.rs_free_cnt[1], bus.rs_free_cnt[0]};
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;

        // Reset: combinational outputs forced low even with a legal pair presented
        @(negedge clk);
        applyStimulus(1, 1, RS_ALU, 1, 1, RS_BRU, 4'b0000, 0);
        checkOutput("grants_in_reset", grants(), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        idle();
        checkOutput("reset_counts", counts(), 32'h8888);
        checkOutput("reset_credit_err", {31'd0, bus.credit_err}, 32'h0);

        // Pair alu + bru
        applyStimulus(1, 1, RS_ALU, 1, 1, RS_BRU, 4'b0000, 0);
        checkOutput("pair_alu_bru", grants(), {21'd0, 3'b111, 4'b0001, 4'b0100});
        @(negedge clk);
        idle();
        checkOutput("counts_after_pair", counts(), 32'h8787);

        // Bring alu down to 1 with three alu+alu pairs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, RS_ALU, 1, 1, RS_ALU, 4'b0000, 0);
            @(negedge clk);
        end
        idle();
        checkOutput("alu_at_1", counts(), 32'h8781);

        // alu+alu with one credit: slot 1 only, release in same cycle not usable
        applyStimulus(1, 1, RS_ALU, 1, 1, RS_ALU, 4'b0001, 0);
        checkOutput("partial_cycle0", grants(), {21'd0, 3'b100, 4'b0001, 4'b0000});
        @(negedge clk);
        applyStimulus(1, 1, RS_ALU, 1, 1, RS_ALU, 4'b0000, 0);
        checkOutput("partial_cycle1", grants(), {21'd0, 3'b011, 4'b0000, 4'b0001});
        @(negedge clk);
        idle();
        checkOutput("alu_at_0", counts(), 32'h8780);

        // Drain agu to 0 while releasing alu back to 4
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, RS_AGU, 1, 1, RS_AGU, 4'b0001, 0);
            @(negedge clk);
        end
        idle();
        checkOutput("agu_drained", counts(), 32'h0784);

        // agu blocked: no out-of-order grant of alu slot 2
        applyStimulus(1, 1, RS_AGU, 1, 1, RS_ALU, 4'b1000, 0);
        checkOutput("in_order_block", grants(), 32'h0);
        @(negedge clk);
        applyStimulus(1, 1, RS_AGU, 1, 1, RS_ALU, 4'b0000, 0);
        checkOutput("in_order_release", grants(), {21'd0, 3'b111, 4'b1000, 4'b0001});
        @(negedge clk);
        idle();
        checkOutput("counts_after_unblock", counts(), 32'h0783);

        // lui-style instruction needs no credit
        applyStimulus(1, 0, RS_AGU, 0, 0, RS_ALU, 4'b0000, 0);
        checkOutput("lui_dispatch", grants(), {21'd0, 3'b101, 4'b0000, 4'b0000});
        @(negedge clk);
        idle();
        checkOutput("lui_no_credit", counts(), 32'h0783);

        // sfu 8 -> 4, then sfu + agu leaves sfu at 3 with slot 2 pending
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, RS_SFU, 1, 1, RS_SFU, 4'b0000, 0);
            @(negedge clk);
        end
        applyStimulus(1, 1, RS_SFU, 1, 1, RS_AGU, 4'b0000, 0);
        checkOutput("sfu_partial", grants(), {21'd0, 3'b100, 4'b0010, 4'b0000});
        @(negedge clk);
        checkOutput("slot2_waiting", grants(), 32'h0);
        checkOutput("sfu_at_3", counts(), 32'h0733);

        // Flush in SLOT2_PENDING with a release that must be ignored
        applyStimulus(1, 1, RS_SFU, 1, 1, RS_AGU, 4'b1111, 1);
        checkOutput("flush_outputs", grants(), 32'h0);
        @(negedge clk);
        idle();
        checkOutput("flush_counts", counts(), 32'h8888);
        applyStimulus(1, 1, RS_SFU, 1, 1, RS_ALU, 4'b0000, 0);
        checkOutput("flush_state_slot1", grants(), {21'd0, 3'b111, 4'b0010, 4'b0001});
        @(negedge clk);
        idle();

        // Overflow on full bru
        applyStimulus(0, 0, RS_ALU, 0, 0, RS_ALU, 4'b0100, 0);
        @(negedge clk);
        idle();
        checkOutput("bru_saturated", {28'd0, bus.rs_free_cnt[2]}, 32'h8);
        checkOutput("credit_err_set", {31'd0, bus.credit_err}, 32'h1);
        applyStimulus(0, 0, RS_ALU, 0, 0, RS_ALU, 4'b0000, 1);
        @(negedge clk);
        idle();
        @(negedge clk);
        checkOutput("credit_err_sticky", {31'd0, bus.credit_err}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("credit_err_cleared", {31'd0, bus.credit_err}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
